// File: rtl/sum_batch_accumulator.sv
// Batch accumulator: folds a stream of unsigned sums into a wide running total
// and emits one {total, count, overflow} record per batch over valid/ready.
module sum_batch_accumulator #(
   parameter int  DATA_W    = 32,
   parameter int  ACC_W     = 40,   // must be >= DATA_W
   parameter int  MAX_BATCH = 16,   // must be >= 1
   localparam int CNT_W     = $clog2(MAX_BATCH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_sum,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [ACC_W-1:0]  out_total,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_overflow,
   output logic              out_valid,
   input  logic              out_ready
);
   typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_t;

   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   logic [ACC_W:0]   w_sum;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_close;

   // One extra bit on the add exposes the carry out of the ACC_W total.
   assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_sum};
   assign w_cnt_nxt  = r_cnt + CNT_W'(1);
   assign w_in_xfer  = in_valid && (r_state == ACCUM);
   assign w_out_xfer = out_ready && (r_state == EMIT);
   assign w_close    = in_last || (w_cnt_nxt == CNT_W'(MAX_BATCH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ACCUM;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_in_xfer) begin
                  r_acc <= w_sum[ACC_W-1:0];
                  r_cnt <= w_cnt_nxt;
                  r_ovf <= r_ovf | w_sum[ACC_W];
                  if (w_close) r_state <= EMIT;
               end
            end
            EMIT: begin
               if (w_out_xfer) begin
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
                  r_state <= ACCUM;
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

   // Handshake flags come from state alone; record fields are the live registers,
   // which cannot change while EMIT waits for the sink.
   assign in_ready     = (r_state == ACCUM);
   assign out_valid    = (r_state == EMIT);
   assign out_total    = r_acc;
   assign out_count    = r_cnt;
   assign out_overflow = r_ovf;
endmodule

// File: doc/sum_batch_accumulator.md
# sum_batch_accumulator

Downstream consumer of the adder's result stream. Accepts 32-bit sums over a valid/ready handshake, accumulates them into a wide running total, and emits one batch record per batch. A batch closes when the producer flags the last element or when `MAX_BATCH` elements have been taken. The record carries the total, the element count and a sticky overflow flag, on a second valid/ready interface.

## Interface
- `DATA_W`, 32, width of incoming sums.
- `ACC_W`, 40, accumulator/total width; must be ≥ `DATA_W`.
- `MAX_BATCH`, 16, maximum elements per batch; must be ≥ 1.
- `CNT_W`, `$clog2(MAX_BATCH+1)`, count width (derived, not overridden).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_sum`  in  `DATA_W`  sum from the adder, unsigned.
- `in_valid`  in  1  `in_sum`/`in_last` valid.
- `in_last`  in  1  current element closes the batch.
- `in_ready`  out  1  block can accept an element this cycle.
- `out_total`  out  `ACC_W`  batch total, modulo 2^`ACC_W`.
- `out_count`  out  `CNT_W`  elements in batch, 1..`MAX_BATCH`.
- `out_overflow`  out  1  carry out of `ACC_W` occurred during this batch.
- `out_valid`  out  1  batch record valid.
- `out_ready`  in  1  sink takes record.

## Operation
- State machine, two states: ACCUM and EMIT. Reset state is ACCUM.
- Input transfer: `in_valid && in_ready` at a rising edge. Output transfer: `out_valid && out_ready` at a rising edge.
- ACCUM:
  - `in_ready`=1, `out_valid`=0.
  - On input transfer: `acc <= acc + zero_extend(in_sum)` (`ACC_W`+1-bit add); `cnt <= cnt+1`.
  - On the same transfer, `ovf <= ovf | carry`.
  - If `in_last`=1 or `cnt+1 == MAX_BATCH`, go to EMIT.
- EMIT:
  - `in_ready`=0, `out_valid`=1.
  - `out_total`=acc, `out_count`=cnt, `out_overflow`=ovf.
  - These outputs are held stable until the output transfer.
  - On output transfer: `acc`, `cnt` and `ovf` clear to 0; go to ACCUM.
- `in_ready` and `out_valid` are decoded from state only. There is no combinational path from any input to any output.
- `in_sum` and `in_last` are ignored when `in_valid`=0 or `in_ready`=0.
- Reaching the `MAX_BATCH` limit closes the batch whether `in_last` is 0 or 1; `in_last`=1 on that same element does not create an extra batch.
- An empty batch cannot be emitted; `out_count` is always ≥ 1 when `out_valid`=1.
- Overflow:
  - Total wraps modulo 2^`ACC_W`.
  - `out_overflow` sets on the first carry and stays set until the record is consumed.

## Timing
- Reset (`rst_n`=0 at an edge) puts the block in ACCUM with `acc`=0, `cnt`=0, `ovf`=0.
- Output values after reset: `in_ready`=1, `out_valid`=0, `out_total`=0, `out_count`=0, `out_overflow`=0.
- Reset mid-batch or during EMIT discards the partial batch or pending record; there is no output transfer.
- Reset has priority over any concurrent handshake.
- Latency: the closing element is accepted at edge k; `out_valid`=1 from cycle k+1.
- Minimum EMIT duration is 1 cycle. With `out_ready` held at 1, the output transfer occurs at edge k+1 and `in_ready`=1 again in cycle k+2.
- Peak throughput: one element per cycle within a batch, plus one bubble cycle per batch.
- Backpressure: while `out_ready`=0, EMIT holds indefinitely, `in_ready` stays 0, and record outputs do not change.
- An input transfer and an output transfer can never occur at the same edge, because the states are exclusive.
- Upstream producers that hold `in_valid` and data while `in_ready`=0 lose no elements.

## Test plan
- Reset, then 3 sums 10, 20, 30 with `in_last` on the third, `out_ready`=1.
  - Required: one record, total=60, count=3, overflow=0.
  - `out_valid` high exactly 1 cycle, in the cycle after the third acceptance.
- 16 back-to-back sums of 1 with `in_last`=0, then a 17th sum of 5.
  - Required: first record total=16, count=16.
  - `in_ready`=0 for one cycle; the 17th element is accepted after it.
  - Second batch starts with acc=5, count=1.
- `ACC_W`=33 build: sums 0xFFFFFFFF ×3 with last on the third.
  - Required: total=0x0FFFFFFFD, count=3, overflow=1.
  - Next batch of a single 7: total=7, overflow=0.
- Single-element batch 42 with last, `out_ready`=0 for 5 cycles, `in_valid` held with value 99.
  - Required: record total=42, count=1 held stable for 5 cycles; `in_ready`=0 throughout.
  - 99 is accepted only after the output transfer.
- Randomised `in_valid`/`out_ready` gaps on batches of lengths 1, 2, 7, 16, checked against a reference-model scoreboard.
  - Required: every total and count matches the model; no element lost or duplicated.
- Assert `rst_n`=0 for 1 cycle after 2 elements (5, 6), then send a batch of 4 with last.
  - Required: no record for the partial batch; next record total=4, count=1.
